// File: rtl/mac_ctrl_pkg.sv
// Shared types and timing constants for the MAC operand sequencer.
// The state encoding and control bundle are used by mac_seq_ctrl.
package mac_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        GET,
        LD,
        ACC,
        FLUSH_Z,
        FLUSH_LD,
        FLUSH_ACC,
        WAIT,
        PLD,
        OUT0,
        OUT1,
        DONE
    } state_t;

    localparam int BYTES_PER_ELEM = 4;
    localparam int FLUSH_CYCLES   = 2;
    localparam int PIPE_WAIT      = 1;

    typedef struct packed {
        logic [3:0] ld;
        logic       clken;
        logic       rst;
        logic       sld;
        logic       res_valid;
        logic       res_idx;
        logic       ready;
        logic       busy;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/mac_ctrl_stall_cnt.sv
// Saturating count of GET cycles starved of input (built with STALL_CNT_EN).
// Cleared at the start of each job, holds its value between jobs.
`ifdef STALL_CNT_EN
module mac_ctrl_stall_cnt (
    input  logic        clk,
    input  logic        aclr,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/mac_seq_ctrl.sv
// Sequencer steering operand bytes onto the shared MAC bus and driving its strobes.
// Define STALL_CNT_EN to add the stall_cnt output.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic [7:0]       mac_in,
    output logic             mac_ld1,
    output logic             mac_ld2,
    output logic             mac_ld3,
    output logic             mac_ld4,
    output logic             mac_clken,
    output logic             mac_rst,
    output logic             mac_ld,
    output logic             res_valid,
    output logic             res_idx,
    output logic             busy,
`ifdef STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             done
);

    state_t           state;
    state_t           next;
    ctrl_t            ctrl_d;
    ctrl_t            ctrl_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] elem;
    logic [LEN_W-1:0] elem_inc;
    logic [1:0]       idx;
    logic [1:0]       fcnt;
    logic             hs;

    assign hs       = (state == GET) && s_valid && s_ready;
    assign elem_inc = elem + LEN_W'(1);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state  <= IDLE;
            len_q  <= '0;
            elem   <= '0;
            idx    <= '0;
            fcnt   <= '0;
            mac_in <= '0;
            ctrl_q <= '0;
        end else begin
            state  <= next;
            ctrl_q <= ctrl_d;
            if (state == IDLE && start) len_q <= len;
            if (state == CLR) begin
                elem <= '0;
                idx  <= '0;
            end else begin
                if (state == LD)  idx  <= idx + 2'd1;
                if (state == ACC) elem <= elem_inc;
            end
            // fcnt times multi-cycle states and restarts on every transition
            fcnt <= (next != state) ? 2'd0 : fcnt + 2'd1;
            if (hs) begin
                mac_in <= s_data;
            end else if (state == FLUSH_Z) begin
                mac_in <= '0;
            end
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:      if (start) next = CLR;
            CLR:       next = (len_q == '0) ? FLUSH_Z : GET;
            GET:       if (hs) next = LD;
            LD:        next = (idx == 2'(BYTES_PER_ELEM - 1)) ? ACC : GET;
            ACC:       next = (elem_inc == len_q) ? FLUSH_Z : GET;
            FLUSH_Z:   next = FLUSH_LD;
            FLUSH_LD:  next = FLUSH_ACC;
            FLUSH_ACC: if (fcnt == 2'(FLUSH_CYCLES - 1)) next = WAIT;
            WAIT:      if (fcnt == 2'(PIPE_WAIT - 1)) next = PLD;
            PLD:       next = OUT0;
            OUT0:      next = OUT1;
            OUT1:      next = DONE;
            DONE:      next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // Outputs decode the upcoming state so the registered copy aligns with it
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.busy = (next != IDLE);
        unique case (next)
            CLR:            ctrl_d.rst = 1'b1;
            GET:            ctrl_d.ready = 1'b1;
            LD:             ctrl_d.ld[idx] = 1'b1;
            ACC, FLUSH_ACC: ctrl_d.clken = 1'b1;
            FLUSH_LD:       ctrl_d.ld = 4'hF;
            PLD:            ctrl_d.sld = 1'b1;
            OUT0:           ctrl_d.res_valid = 1'b1;
            OUT1: begin
                ctrl_d.res_valid = 1'b1;
                ctrl_d.res_idx   = 1'b1;
            end
            DONE:           ctrl_d.done = 1'b1;
            default: ;
        endcase
    end

    assign s_ready   = ctrl_q.ready;
    assign mac_ld1   = ctrl_q.ld[0];
    assign mac_ld2   = ctrl_q.ld[1];
    assign mac_ld3   = ctrl_q.ld[2];
    assign mac_ld4   = ctrl_q.ld[3];
    assign mac_clken = ctrl_q.clken;
    assign mac_rst   = ctrl_q.rst;
    assign mac_ld    = ctrl_q.sld;
    assign res_valid = ctrl_q.res_valid;
    assign res_idx   = ctrl_q.res_idx;
    assign busy      = ctrl_q.busy;
    assign done      = ctrl_q.done;

`ifdef STALL_CNT_EN
    mac_ctrl_stall_cnt u_stall (
        .clk  (clk),
        .aclr (aclr),
        .clr  (state == CLR),
        .inc  (state == GET && !s_valid),
        .cnt  (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural MAC datapath model.
// Honours STALL_CNT_EN for the optional stall counter.
module tb_mac_seq_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             aclr = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             s_valid = 1'b0;
    logic [7:0]       s_data = '0;
    logic             s_ready;
    logic [7:0]       mac_in;
    logic             mac_ld1, mac_ld2, mac_ld3, mac_ld4;
    logic             mac_clken, mac_rst, mac_ld;
    logic             res_valid, res_idx, busy, done;
`ifdef STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .start     (start),
        .len       (len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mac_in    (mac_in),
        .mac_ld1   (mac_ld1),
        .mac_ld2   (mac_ld2),
        .mac_ld3   (mac_ld3),
        .mac_ld4   (mac_ld4),
        .mac_clken (mac_clken),
        .mac_rst   (mac_rst),
        .mac_ld    (mac_ld),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .busy      (busy),
`ifdef STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t0;
        int          lat;
        int          n;
        int          sumg;
        int unsigned acc1;
        int unsigned acc2;
    } job_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   jobs_done = 0;
    job_t job_q[$];
    int   load_q[$];
    int   src_d[$];
    int   src_g[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic longint outs();
        return {s_ready, mac_in, mac_ld1, mac_ld2, mac_ld3, mac_ld4,
                mac_clken, mac_rst, mac_ld, res_valid, res_idx, busy, done};
    endfunction

    // Byte source: gap cycles are spent only while the DUT is asking for data
    logic rdy_q = 1'b0;
    always @(negedge clk) begin
        if (aclr) begin
            rdy_q = 1'b0;
            s_valid = 1'b0;
            src_d.delete();
            src_g.delete();
        end else begin
            if (s_valid && rdy_q && src_d.size() > 0) begin
                src_d.delete(0);
                src_g.delete(0);
            end
            rdy_q = s_ready;
            if (src_d.size() == 0) begin
                s_valid = 1'b0;
            end else if (s_ready && src_g[0] > 0) begin
                s_valid = 1'b0;
                src_g[0] = src_g[0] - 1;
            end else begin
                s_valid = 1'b1;
                s_data = 8'(src_d[0]);
            end
        end
    end

    int          m_rst, m_rcyc, m_ld, m_fld, m_clk, m_rdy, m_busy;
    int          m_pld, m_r0, m_r1, k, nstb;
    int unsigned op[4];
    int unsigned p1a, p1b, p2a, p2b, a1, a2, cap1, cap2;
    logic        prev_strobe;
    logic [7:0]  prev_in;
    logic [3:0]  ld;
    int          e;
    job_t        j;

    function automatic void clear_job();
        m_rst = 0; m_rcyc = -1; m_ld = 0; m_fld = 0; m_clk = 0;
        m_rdy = 0; m_busy = 0; m_pld = -1; m_r0 = -1; m_r1 = -1;
    endfunction

    always @(negedge clk) begin
        if (aclr) begin
            clear_job();
            job_q.delete();
            load_q.delete();
            prev_strobe = 1'b0;
            prev_in = '0;
            op = '{default: 0};
            p1a = 0; p1b = 0; p2a = 0; p2b = 0; a1 = 0; a2 = 0;
        end else begin
            ld = {mac_ld4, mac_ld3, mac_ld2, mac_ld1};
            if (prev_strobe) chk("mac_in_hold", mac_in, prev_in);
            nstb = $countones({ld, mac_clken});
            if (nstb != 0) chk("strobe_count", nstb, (ld == 4'hF) ? 4 : 1);
            if (mac_rst) begin
                m_rst++;
                m_rcyc = cyc;
                op = '{default: 0};
                p1a = 0; p1b = 0; p2a = 0; p2b = 0; a1 = 0; a2 = 0;
            end
            if (ld == 4'hF) begin
                m_fld++;
                chk("flush_operand", mac_in, 0);
                for (int i = 0; i < 4; i++) op[i] = mac_in;
            end else if (ld != 4'h0) begin
                m_ld++;
                k = ld[0] ? 0 : ld[1] ? 1 : ld[2] ? 2 : 3;
                if (load_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load actual=ld%0d required=none", k + 1);
                end else begin
                    e = load_q.pop_front();
                    chk("load_lane", k, e / 256);
                    chk("load_byte", mac_in, e % 256);
                end
                op[k] = mac_in;
            end
            if (mac_clken) begin
                m_clk++;
                a1 += p2a;
                a2 += p2b;
                p2a = p1a;
                p2b = p1b;
                p1a = op[0] * op[1];
                p1b = op[2] * op[3];
            end
            if (s_ready) m_rdy++;
            if (busy) m_busy++;
            if (mac_ld) begin
                m_pld = cyc;
                cap1 = a1;
                cap2 = a2;
            end
            if (res_valid) begin
                if (res_idx) m_r1 = cyc;
                else m_r0 = cyc;
            end
            if (done) begin
                if (job_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=cycle %0d required=no done", cyc);
                end else begin
                    j = job_q.pop_front();
                    chk("latency", cyc - j.t0, j.lat);
                    chk("rst_pulses", m_rst, 1);
                    chk("rst_cycle", m_rcyc, j.t0 + 1);
                    chk("single_loads", m_ld, 4 * j.n);
                    chk("flush_loads", m_fld, 1);
                    chk("clken_pulses", m_clk, j.n + 2);
                    chk("ready_cycles", m_rdy, 4 * j.n + j.sumg);
                    chk("busy_cycles", m_busy, j.lat);
                    chk("pld_cycle", m_pld, j.t0 + j.lat - 3);
                    chk("res0_cycle", m_r0, j.t0 + j.lat - 2);
                    chk("res1_cycle", m_r1, j.t0 + j.lat - 1);
                    chk("acc_lane1", cap1, j.acc1);
                    chk("acc_lane2", cap2, j.acc2);
`ifdef STALL_CNT_EN
                    chk("stall_cnt", stall_cnt, j.sumg);
`endif
                end
                jobs_done++;
                clear_job();
            end
            prev_strobe = (ld != 4'h0);
            prev_in = mac_in;
        end
    end

    task automatic run_job(input int n, input bit fixed, input int gmode,
                           input bit extra, input int abort_at);
        job_t        jb;
        int          d[4];
        int          g;
        int          sumg = 0;
        int unsigned s1 = 0;
        int unsigned s2 = 0;
        int          target;
        bit          got = 1'b0;
        for (int el = 0; el < n; el++) begin
            for (int b = 0; b < 4; b++) begin
                d[b] = fixed ? 3 + b : int'($urandom_range(0, 255));
                g = (gmode == 1) ? ((b == 2) ? 2 : 0) :
                    (gmode == 2) ? int'($urandom_range(0, 3)) : 0;
                sumg += g;
                src_d.push_back(d[b]);
                src_g.push_back(g);
                load_q.push_back(b * 256 + d[b]);
            end
            s1 += d[0] * d[1];
            s2 += d[2] * d[3];
        end
        jb.n = n;
        jb.sumg = sumg;
        jb.acc1 = s1;
        jb.acc2 = s2;
        jb.lat = 10 + 9 * n + sumg;
        @(negedge clk);
        len = LEN_W'(n);
        start = 1'b1;
        jb.t0 = cyc;
        job_q.push_back(jb);
        target = jobs_done + 1;
        @(negedge clk);
        start = 1'b0;
        len = LEN_W'($urandom);
        if (abort_at >= 0) begin
            while (cyc < jb.t0 + abort_at) @(negedge clk);
            #2 aclr = 1'b1;
            #1;
            chk("abort_outputs", outs(), 0);
`ifdef STALL_CNT_EN
            chk("abort_stall_cnt", stall_cnt, 0);
`endif
            target = jobs_done;
            @(negedge clk);
            @(negedge clk);
            #2 aclr = 1'b0;
            repeat (30) @(negedge clk);
            chk("no_done_after_abort", jobs_done, target);
            return;
        end
        if (extra) begin
            repeat ($urandom_range(1, 7)) @(negedge clk);
            start = 1'b1;
            len = LEN_W'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < jb.lat + 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (jobs_done >= target) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done after %0d cycles", jb.lat);
        end
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
`ifdef STALL_CNT_EN
        chk("stall_hold", stall_cnt, sumg);
`endif
    endtask

    initial begin
        #1;
        chk("reset_outputs", outs(), 0);
`ifdef STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        #2 aclr = 1'b0;
        run_job(1, 1'b1, 0, 1'b0, -1);
        run_job(3, 1'b0, 1, 1'b0, -1);
        run_job(0, 1'b0, 0, 1'b0, -1);
        run_job(2, 1'b0, 0, 1'b1, -1);
        run_job(2, 1'b0, 0, 1'b0, 6);
        run_job(1, 1'b1, 0, 1'b0, -1);
        for (int t = 0; t < 20; t++) begin
            run_job(int'($urandom_range(0, 5)), 1'b0, 2, 1'(($urandom % 2)), -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the dual-lane MAC datapath.
- Accepts a valid/ready byte stream of operand quadruples and steers them one at a time onto the shared 8-bit MAC operand bus, pulsing the four operand-load strobes.
- Issues one accumulate enable per element, then flushes the 2-stage multiply pipeline with zero operands.
- Loads the 16-bit result into the serialiser and flags the two output bytes (post-activation) as valid.

Parameters:
- LEN_W, 8, width of the dot-product length input; max length 2^LEN_W-1.

Ports:
- clk  in  1  clock
- aclr  in  1  asynchronous reset, active-high
- start  in  1  begin a dot-product; sampled only in IDLE
- len  in  LEN_W  element count, latched on start
- s_valid  in  1  operand byte valid
- s_data  in  8  operand byte; order per element: lane1 A, lane1 B, lane2 A, lane2 B
- s_ready  out  1  byte accepted when s_valid&s_ready
- mac_in  out  8  registered operand bus to MAC
- mac_ld1..mac_ld4  out  1 each  operand register load strobes; registered, glitch-free
- mac_clken  out  1  accumulator clock enable
- mac_rst  out  1  datapath clear (operands, accumulators, serialiser)
- mac_ld  out  1  serialiser parallel load
- res_valid  out  1  activation output valid this cycle
- res_idx  out  1  0 = lane2 byte, 1 = lane1 byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of job

Behaviour:
- Reset (aclr high, async): state IDLE. All outputs 0, mac_in=0, counters 0.
- All outputs are registered. Exactly one mac_ld* or mac_clken strobe is active per cycle, except FLUSH_LD, where all four load strobes fire together.
- mac_in changes only in a cycle before a load strobe is asserted. It holds through the strobe's rising edge.
- IDLE: on start, latch len and go to CLR. start is ignored while busy.
- CLR: mac_rst=1 for 1 cycle. Element counter and byte index cleared. Next state GET, or FLUSH_Z if len==0.
- GET: s_ready=1. On handshake: mac_in<=s_data and go to LD. No handshake: stay in GET (stall, no timeout).
- LD: mac_ld[idx+1]=1 for 1 cycle, then idx++. If idx was 3, go to ACC; else go to GET.
- ACC: mac_clken=1 for 1 cycle, then elem++. If elem==len, go to FLUSH_Z; else go to GET.
- FLUSH_Z: mac_in<=0, 1 cycle.
- FLUSH_LD: mac_ld1..4=1, 1 cycle, loads zero operands.
- FLUSH_ACC: mac_clken=1 for 2 consecutive cycles. Drains the operand and product pipeline stages; the zero product adds nothing.
- WAIT: 1 cycle, covers the result truncation register stage.
- PLD: mac_ld=1 for 1 cycle.
- OUT0: res_valid=1, res_idx=0.
- OUT1: res_valid=1, res_idx=1.
- DONE: done=1 for 1 cycle, then IDLE.
- len=1 with s_valid constant high: start seen in cycle 0 → mac_rst cycle 1 → loads cycles 2–9 (GET/LD pairs) → clken 10 → flush cycles 11–14 → WAIT 15 → mac_ld 16 → res_valid 17,18 → done 19. Each extra element adds 9 cycles.
- Counter widths: elem is LEN_W bits; idx is 2 bits, wraps at 4.
- aclr mid-job: abort immediately to IDLE. The partial job is discarded; no done pulse.
- s_valid dropping mid-element: stall in GET; already-loaded operand registers are retained.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0]: counts GET cycles with s_valid=0.
  - Cleared in CLR; saturates at 16'hFFFF.
  - Reset 0; holds its value after done until the next start.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package mac_ctrl_pkg:
  - state enum (IDLE, CLR, GET, LD, ACC, FLUSH_Z, FLUSH_LD, FLUSH_ACC, WAIT, PLD, OUT0, OUT1, DONE)
  - BYTES_PER_ELEM=4, FLUSH_CYCLES=2, PIPE_WAIT=1
- Single FSM module.
- Optional sub-module mac_ctrl_stall_cnt for the saturating counter under STALL_CNT_EN.

Test Plan:
- len=1, bytes 3,4,5,6, s_valid held high → strobes exactly as in the cycle list above.
  - Lane accumulators reach 12 and 30.
  - res_valid in cycles 17–18, done in cycle 19.
- len=3, with s_valid low 2 cycles before every third byte → 3 ACC clken pulses plus 2 flush pulses.
  - 12 load strobes plus 1 four-wide flush load.
  - stall_cnt=6 when STALL_CNT_EN is defined.
- len=0 → no s_ready.
  - mac_rst, flush, then mac_ld; res_valid for 2 cycles; done at cycle 10.
- start pulsed while busy → ignored; the in-flight job completes with an unchanged cycle count.
- aclr asserted in cycle 6 of a len=2 job → all outputs 0 immediately, no done.
  - A new start then runs normally, beginning with mac_rst.
- mac_in stability → checker confirms mac_in is unchanged at every rising edge of any mac_ld*.
